// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : MEM-stage load/store unit. Drives a req/gnt/rvalid data-memory
//            port, lane-replicates store data, aligns and extends load data,
//            and retires one result per instruction with a one-cycle
//            out_valid pulse.
// Options  : LSU_MISALIGN_TRAP_EN - when defined, misaligned H/W accesses are
//            not sent to memory and retire with misalign=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int ADDR_SIZE = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   ex_valid,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             funct3,
  input  logic [WORD_SIZE-1:0]   addr,
  input  logic [WORD_SIZE-1:0]   store_data,
  input  logic [REG_SEL-1:0]     rd,
  input  logic                   reg_write,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [ADDR_SIZE-1:0]   dmem_addr,
  output logic [WORD_SIZE-1:0]   dmem_wdata,
  output logic [WORD_SIZE/8-1:0] dmem_be,
  input  logic                   dmem_gnt,
  input  logic                   dmem_rvalid,
  input  logic [WORD_SIZE-1:0]   dmem_rdata,
  output logic [WORD_SIZE-1:0]   read_data,
  output logic [WORD_SIZE-1:0]   result,
  output logic [REG_SEL-1:0]     rd_out,
  output logic                   mem_read_out,
  output logic                   reg_write_out,
  output logic                   out_valid,
  output logic                   misalign,
  output logic                   stall_req
);

  localparam int BE_W = WORD_SIZE / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] store_data_q, store_data_d;
  logic [REG_SEL-1:0]   rd_q, rd_d;
  logic                 reg_write_q, reg_write_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 misalign_q, misalign_d;
  logic                 drain_q, drain_d;   // flushed in WAIT, swallow the rvalid

  logic                 is_mem;
  logic                 trap;
  logic [BE_W-1:0]      be_raw;
  logic [WORD_SIZE-1:0] wdata_raw;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;

  // Misalignment detection on the incoming instruction (only used when trapping)
  always_comb begin
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (funct3[1:0])
      2'b01:   trap = addr[0];
      2'b10:   trap = (addr[1:0] != 2'b00);
      default: trap = 1'b0;
    endcase
`endif
  end

  // Next-state and control: accept in IDLE/DONE, handshake in REQ/WAIT
  always_comb begin
    state_d      = state_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    rdata_d      = rdata_q;
    misalign_d   = misalign_q;
    drain_d      = drain_q;
    dmem_req     = 1'b0;
    stall_req    = 1'b0;
    out_valid    = 1'b0;
    is_mem       = mem_read | mem_write;

    case (state_q)
      IDLE, DONE: begin
        out_valid  = (state_q == DONE);
        state_d    = IDLE;
        misalign_d = 1'b0;
        drain_d    = 1'b0;
        if (ex_valid && !flush) begin
          mem_read_d   = mem_read;
          mem_write_d  = mem_write;
          funct3_d     = funct3;
          addr_d       = addr;
          store_data_d = store_data;
          rd_d         = rd;
          reg_write_d  = reg_write;
          if (is_mem) begin
            stall_req = 1'b1;
            if (trap) begin
              state_d    = DONE;
              misalign_d = 1'b1;
            end else begin
              state_d = REQ;
            end
          end else begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        stall_req = 1'b1;
        dmem_req  = !flush;
        if (flush) begin
          state_d = IDLE;
        end else if (dmem_gnt) begin
          state_d = mem_write_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall_req = 1'b1;
        if (dmem_rvalid) begin
          rdata_d = dmem_rdata;
          drain_d = 1'b0;
          state_d = (drain_q || flush) ? IDLE : DONE;
        end else if (flush) begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-instruction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      rdata_q      <= '0;
      misalign_q   <= 1'b0;
      drain_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      rdata_q      <= rdata_d;
      misalign_q   <= misalign_d;
      drain_q      <= drain_d;
    end
  end

  // Store byte enables and lane-replicated write data from the latched op
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be_raw    = BE_W'(1) << addr_q[1:0];
        wdata_raw = {BE_W{store_data_q[7:0]}};
      end
      2'b01: begin
        be_raw    = BE_W'(3) << {addr_q[1], 1'b0};
        wdata_raw = {(BE_W/2){store_data_q[15:0]}};
      end
      default: begin
        be_raw    = {BE_W{1'b1}};
        wdata_raw = store_data_q;
      end
    endcase
  end

  // Load alignment and sign/zero extension of the captured word
  always_comb begin
    ld_byte = 8'(rdata_q >> {addr_q[1:0], 3'b000});
    ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_q)
      3'b000:  read_data = {{(WORD_SIZE-8){ld_byte[7]}}, ld_byte};
      3'b001:  read_data = {{(WORD_SIZE-16){ld_half[15]}}, ld_half};
      3'b100:  read_data = {{(WORD_SIZE-8){1'b0}}, ld_byte};
      3'b101:  read_data = {{(WORD_SIZE-16){1'b0}}, ld_half};
      default: read_data = rdata_q;
    endcase
  end

  // Memory port is quiet (all zero) whenever no request is outstanding
  assign dmem_we       = dmem_req & mem_write_q;
  assign dmem_addr     = dmem_req ? addr_q[ADDR_SIZE+1:2] : '0;
  assign dmem_be       = dmem_req ? be_raw : '0;
  assign dmem_wdata    = dmem_req ? wdata_raw : '0;

  assign result        = addr_q;
  assign rd_out        = rd_q;
  assign mem_read_out  = mem_read_q;
  assign reg_write_out = reg_write_q & out_valid & ~misalign_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = out_valid & misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] read_data;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        mem_read_out;
  logic        reg_write_out;
  logic        out_valid;
  logic        misalign;
  logic        stall_req;

  int tests_run;
  int tests_failed;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .rd           (rd),
    .reg_write    (reg_write),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .read_data    (read_data),
    .result       (result),
    .rd_out       (rd_out),
    .mem_read_out (mem_read_out),
    .reg_write_out(reg_write_out),
    .out_valid    (out_valid),
    .misalign     (misalign),
    .stall_req    (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    flush       = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    reg_write   = 1'b0;
  endtask

  task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] r, input logic rw);
    ex_valid   = 1'b1;
    mem_read   = rd_en;
    mem_write  = wr_en;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    rd         = r;
    reg_write  = rw;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    funct3       = 3'b000;
    addr         = '0;
    store_data   = '0;
    rd           = '0;
    dmem_rdata   = '0;
    clear_inputs();
    repeat (2) cyc();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dmem_req",  32'(dmem_req),  32'd0);
    check("rst_stall",     32'(stall_req), 32'd0);
    check("rst_result",    result,         32'd0);
    check("rst_read_data", read_data,      32'd0);
    check("rst_rd_out",    32'(rd_out),    32'd0);
    check("rst_misalign",  32'(misalign),  32'd0);
    rst = 1'b0;
    cyc();

    // ALU op: latency 1, no stall
    issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
    #1 check("alu_stall_accept", 32'(stall_req), 32'd0);
    cyc(); clear_inputs(); #1;
    check("alu_out_valid", 32'(out_valid),     32'd1);
    check("alu_result",    result,             32'h1234);
    check("alu_rd_out",    32'(rd_out),        32'd5);
    check("alu_rwo",       32'(reg_write_out), 32'd1);
    check("alu_stall",     32'(stall_req),     32'd0);
    cyc(); #1 check("alu_one_pulse", 32'(out_valid), 32'd0);

    // SB at addr 7, grant in first REQ cycle
    issue(1'b0, 1'b1, 3'b000, 32'h7, 32'hA5, 5'd0, 1'b0);
    #1 check("sb_stall_accept", 32'(stall_req), 32'd1);
    cyc(); clear_inputs(); dmem_gnt = 1'b1; #1;
    check("sb_req",   32'(dmem_req),  32'd1);
    check("sb_we",    32'(dmem_we),   32'd1);
    check("sb_be",    32'(dmem_be),   32'b1000);
    check("sb_wdata", dmem_wdata,     32'hA5A5A5A5);
    check("sb_addr",  32'(dmem_addr), 32'd1);
    check("sb_ov_early", 32'(out_valid), 32'd0);
    cyc(); dmem_gnt = 1'b0; #1;
    check("sb_out_valid", 32'(out_valid),     32'd1);
    check("sb_rwo",       32'(reg_write_out), 32'd0);
    check("sb_req_done",  32'(dmem_req),      32'd0);
    cyc();

    // SH at addr 2: upper half lanes
    issue(1'b0, 1'b1, 3'b001, 32'h2, 32'h1234BEEF, 5'd0, 1'b0);
    cyc(); clear_inputs(); dmem_gnt = 1'b1; #1;
    check("sh_be",    32'(dmem_be), 32'b1100);
    check("sh_wdata", dmem_wdata,   32'hBEEFBEEF);
    cyc(); dmem_gnt = 1'b0; #1;
    check("sh_out_valid", 32'(out_valid), 32'd1);
    cyc();

    // LB at addr 2, grant delayed two cycles, rvalid one cycle after grant
    issue(1'b1, 1'b0, 3'b000, 32'h2, 32'h0, 5'd7, 1'b1);
    #1 check("lb_stall_accept", 32'(stall_req), 32'd1);
    cyc(); clear_inputs(); #1;
    check("lb_req_c1",   32'(dmem_req),  32'd1);
    check("lb_stall_c1", 32'(stall_req), 32'd1);
    cyc(); #1;
    check("lb_req_c2",   32'(dmem_req),  32'd1);
    check("lb_stall_c2", 32'(stall_req), 32'd1);
    cyc(); dmem_gnt = 1'b1; #1;
    check("lb_req_c3", 32'(dmem_req), 32'd1);
    check("lb_we",     32'(dmem_we),  32'd0);
    cyc(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h00800000; #1;
    check("lb_req_wait",   32'(dmem_req),  32'd0);
    check("lb_stall_wait", 32'(stall_req), 32'd1);
    check("lb_ov_wait",    32'(out_valid), 32'd0);
    cyc(); dmem_rvalid = 1'b0; #1;
    check("lb_out_valid", 32'(out_valid),     32'd1);
    check("lb_read_data", read_data,          32'hFFFFFF80);
    check("lb_rd_out",    32'(rd_out),        32'd7);
    check("lb_rwo",       32'(reg_write_out), 32'd1);
    check("lb_mro",       32'(mem_read_out),  32'd1);
    check("lb_stall_done", 32'(stall_req),    32'd0);
    cyc(); #1 check("lb_one_pulse", 32'(out_valid), 32'd0);

    // LHU at addr 2: zero-extended upper half
    issue(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 5'd8, 1'b1);
    cyc(); clear_inputs(); dmem_gnt = 1'b1;
    cyc(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF0000;
    cyc(); dmem_rvalid = 1'b0; #1;
    check("lhu_out_valid", 32'(out_valid), 32'd1);
    check("lhu_read_data", read_data,      32'h0000BEEF);
    cyc();

    // LHU flushed in WAIT: drain the rvalid, then IDLE with no retire
    issue(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 5'd9, 1'b1);
    cyc(); clear_inputs(); dmem_gnt = 1'b1;
    cyc(); dmem_gnt = 1'b0; flush = 1'b1; #1;
    check("fw_stall_flush", 32'(stall_req), 32'd1);
    cyc(); flush = 1'b0; #1;
    check("fw_ov_drain",    32'(out_valid), 32'd0);
    check("fw_stall_drain", 32'(stall_req), 32'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    cyc(); dmem_rvalid = 1'b0; #1;
    check("fw_ov_after",    32'(out_valid), 32'd0);
    check("fw_stall_after", 32'(stall_req), 32'd0);
    check("fw_req_after",   32'(dmem_req),  32'd0);
    cyc(); #1 check("fw_ov_idle", 32'(out_valid), 32'd0);

    // Flush in REQ: request withdrawn immediately, back to IDLE
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd2, 1'b1);
    cyc(); clear_inputs(); flush = 1'b1; dmem_gnt = 1'b1; #1;
    check("fr_req_drop", 32'(dmem_req), 32'd0);
    cyc(); flush = 1'b0; dmem_gnt = 1'b0; #1;
    check("fr_ov",    32'(out_valid), 32'd0);
    check("fr_stall", 32'(stall_req), 32'd0);

    // LW at addr 6: trapped or low bits ignored depending on build
    issue(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 5'd3, 1'b1);
    #1 check("lw6_stall_accept", 32'(stall_req), 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
    cyc(); clear_inputs(); #1;
    check("lw6_no_req",   32'(dmem_req),      32'd0);
    check("lw6_ov",       32'(out_valid),     32'd1);
    check("lw6_misalign", 32'(misalign),      32'd1);
    check("lw6_rwo",      32'(reg_write_out), 32'd0);
    cyc();
`else
    cyc(); clear_inputs(); dmem_gnt = 1'b1; #1;
    check("lw6_req",  32'(dmem_req),  32'd1);
    check("lw6_addr", 32'(dmem_addr), 32'd1);
    check("lw6_be",   32'(dmem_be),   32'b1111);
    cyc(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    cyc(); dmem_rvalid = 1'b0; #1;
    check("lw6_ov",        32'(out_valid),     32'd1);
    check("lw6_misalign",  32'(misalign),      32'd0);
    check("lw6_read_data", read_data,          32'hCAFEF00D);
    check("lw6_rwo",       32'(reg_write_out), 32'd1);
    cyc();
`endif

    // Reset while in REQ, then a late rvalid must be ignored
    issue(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 5'd4, 1'b1);
    cyc(); clear_inputs(); #1;
    check("rr_req_before", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    check("rr_req",       32'(dmem_req),      32'd0);
    check("rr_ov",        32'(out_valid),     32'd0);
    check("rr_stall",     32'(stall_req),     32'd0);
    check("rr_result",    result,             32'd0);
    check("rr_rd_out",    32'(rd_out),        32'd0);
    check("rr_read_data", read_data,          32'd0);
    check("rr_mro",       32'(mem_read_out),  32'd0);
    check("rr_rwo",       32'(reg_write_out), 32'd0);
    check("rr_be",        32'(dmem_be),       32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    cyc(); dmem_rvalid = 1'b0; #1;
    check("rr_late_ov",   32'(out_valid), 32'd0);
    check("rr_late_data", read_data,      32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be WORD_SIZE 32 (datapath width), NUM_REGS 32 (register count), REG_SEL $clog2(NUM_REGS) (rd width), ADDR_SIZE 10 (data-memory word-address width).
REQ-002 The design SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-003 Ports SHALL be:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  flush  in  1  discard current instruction
  ex_valid  in  1  instruction present from EX/MEM
  mem_read  in  1  load
  mem_write  in  1  store
  funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
  addr  in  WORD_SIZE  ALU-computed byte address / result
  store_data  in  WORD_SIZE  rs2 value
  rd  in  REG_SEL  destination register
  reg_write  in  1  writeback enable
  dmem_req  out  1  memory request
  dmem_we  out  1  1 = write
  dmem_addr  out  ADDR_SIZE  word address, addr[ADDR_SIZE+1:2]
  dmem_wdata  out  WORD_SIZE  lane-replicated store data
  dmem_be  out  WORD_SIZE/8  byte enables
  dmem_gnt  in  1  request accepted
  dmem_rvalid  in  1  load data valid
  dmem_rdata  in  WORD_SIZE  load data
  read_data  out  WORD_SIZE  aligned, extended load data to MEM/WB
  result  out  WORD_SIZE  registered addr/ALU result
  rd_out  out  REG_SEL  registered rd
  mem_read_out  out  1  registered mem_read
  reg_write_out  out  1  reg_write gated by out_valid
  out_valid  out  1  one-cycle retire pulse
  misalign  out  1  misaligned-access retire flag
  stall_req  out  1  hold upstream stages

Function
REQ-004 The FSM SHALL have states IDLE, REQ, WAIT and DONE; new instructions SHALL be accepted only in IDLE or DONE.
REQ-005 Accepting a non-memory instruction (ex_valid=1, mem_read=mem_write=0) SHALL go to DONE, with outputs valid the next cycle (latency 1).
REQ-006 Accepting a memory instruction SHALL latch all inputs, go to REQ and raise stall_req combinationally in the accept cycle.
REQ-007 In REQ, dmem_req SHALL be 1 and held stable until dmem_gnt=1; a store SHALL then go to DONE and a load to WAIT.
REQ-008 In WAIT, the unit SHALL capture dmem_rdata on dmem_rvalid and go to DONE; dmem_rvalid in any other state SHALL be ignored.
REQ-009 stall_req SHALL be 1 in REQ and WAIT, and in the IDLE/DONE cycle that accepts a memory op; otherwise it SHALL be 0.
REQ-010 In DONE, out_valid SHALL be 1 for exactly one cycle, and reg_write_out SHALL equal the latched reg_write ANDed with out_valid.
REQ-011 Store lanes: SB SHALL drive be=0001<<addr[1:0] and wdata={4{byte}}; SH SHALL drive be=0011<<{addr[1],0} and wdata={2{half}}; SW SHALL drive be=1111.
REQ-012 Loads SHALL select a byte by addr[1:0] and a half by addr[1]; B/H SHALL sign-extend and BU/HU SHALL zero-extend.
REQ-013 When ex_valid=0 in IDLE/DONE, the unit SHALL go to IDLE with out_valid=0.
REQ-014 flush SHALL take precedence over acceptance: in IDLE/DONE, the input SHALL be dropped; in REQ before grant, dmem_req SHALL drop and the FSM SHALL go to IDLE; in WAIT, the unit SHALL drain the rvalid and then go to IDLE without out_valid.

Reset
REQ-015 rst SHALL force IDLE and drive all outputs and internal registers to 0, including mid-transaction; dmem_req SHALL be 0 the cycle after rst.

Configuration
REQ-016 With LSU_MISALIGN_TRAP_EN defined, an H/HU/SH access with addr[0]=1 or a W/SW access with addr[1:0]!=0 SHALL issue no dmem_req, go straight to DONE, and retire with misalign=1 and reg_write_out=0.
REQ-017 Without LSU_MISALIGN_TRAP_EN, misalign SHALL be tied 0, low address bits below the access size SHALL be ignored, and the access SHALL proceed.

Verification
REQ-018 Bench: ALU op, addr=0x1234, rd=5, reg_write=1 -> next cycle out_valid=1, result=0x1234, rd_out=5, stall_req=0.
REQ-019 Bench: SB addr=0x7, store_data=0xA5, gnt on the first REQ cycle -> dmem_be=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=1, out_valid 2 cycles after accept.
REQ-020 Bench: LB addr=0x2, rdata=0x00800000, gnt delayed 2 cycles, rvalid 1 cycle later -> read_data=0xFFFFFF80, stall_req high throughout, out_valid once.
REQ-021 Bench: LHU addr=0x2, rdata=0xBEEF0000 -> read_data=0x0000BEEF; flush in WAIT -> no out_valid, FSM returns to IDLE.
REQ-022 Bench: LW addr=0x6 -> with macro: misalign=1, no dmem_req; without macro: dmem_addr=1 and normal retire.
REQ-023 Bench: rst asserted in REQ -> dmem_req=0 the next cycle, all outputs 0, and a late rvalid is ignored.
